toy_dmem_responder: RTL and testbench

//  Data-memory responder for the RISC_TOY core: the target end of the core's DREQ/DRW/DADDR/DWDATA/DRDATA port.

---
 rtl/toy_dmem_responder.sv | 114 +++++++++++
 tb/tb_toy_dmem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/toy_dmem_responder.sv
// Word-addressed data-memory target for RISC_TOY: reads return after READ_LAT cycles, writes commit in one.
// Never stalls; out-of-range reads return zero, out-of-range writes are dropped, and either sets sticky ERR.
module toy_dmem_responder #(
  parameter int AW       = 10,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             DREQ,
  input  logic             DRW,
  input  logic [29:0]      DADDR,
  input  logic [31:0]      DWDATA,
  output logic [31:0]      DRDATA,
  output logic             RVALID,
  output logic             ERR,
  output logic [CNT_W-1:0] RD_CNT,
  output logic [CNT_W-1:0] WR_CNT
);

  localparam int DEPTH = 2**AW;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("toy_dmem_responder: READ_LAT must be 1 or 2");
  end

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    idx;
  logic             in_rng;
  logic             rd_acc;
  logic             wr_acc;

  logic             s1_vld_q, s1_vld_d;
  logic [31:0]      s1_dat_q, s1_dat_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  assign idx    = DADDR[AW-1:0];
  assign in_rng = ((DADDR >> AW) == 30'd0);
  assign rd_acc = DREQ & ~DRW;
  assign wr_acc = DREQ & DRW;

  always_ff @(posedge CLK) begin
    if (wr_acc && in_rng) begin
      mem_q[idx] <= DWDATA;
    end
  end

  // Data register only loads on a read so the last response is held between reads.
  always_comb begin
    s1_vld_d = rd_acc;
    s1_dat_d = s1_dat_q;
    err_d    = err_q | (DREQ & ~in_rng);
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_acc) begin
      s1_dat_d = in_rng ? mem_q[idx] : 32'd0;
    end
    if (rd_acc && (rd_cnt_q != {CNT_W{1'b1}})) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
    if (wr_acc && (wr_cnt_q != {CNT_W{1'b1}})) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= 32'd0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic        s2_vld_q, s2_vld_d;
    logic [31:0] s2_dat_q, s2_dat_d;

    always_comb begin
      s2_vld_d = s1_vld_q;
      s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        s2_vld_q <= 1'b0;
        s2_dat_q <= 32'd0;
      end else begin
        s2_vld_q <= s2_vld_d;
        s2_dat_q <= s2_dat_d;
      end
    end

    assign RVALID = s2_vld_q;
    assign DRDATA = s2_dat_q;
  end else begin : g_lat1
    assign RVALID = s1_vld_q;
    assign DRDATA = s1_dat_q;
  end

  assign ERR    = err_q;
  assign RD_CNT = rd_cnt_q;
  assign WR_CNT = wr_cnt_q;

endmodule

// File: tb/tb_toy_dmem_responder.sv
// Directed bench: three responders (latency 1, latency 2, 4-bit counters) share one stimulus stream.
module tb_toy_dmem_responder;

  logic        clk;
  logic        rstn;
  logic        dreq;
  logic        drw;
  logic [29:0] daddr;
  logic [31:0] dwdata;

  logic [31:0] a_rdata, b_rdata, c_rdata;
  logic        a_rvld, b_rvld, c_rvld;
  logic        a_err, b_err, c_err;
  logic [15:0] a_rcnt, a_wcnt, b_rcnt, b_wcnt;
  logic [3:0]  c_rcnt, c_wcnt;

  int total = 0;
  int bad   = 0;

  toy_dmem_responder #(.AW(10), .READ_LAT(1), .CNT_W(16)) u_lat1 (
    .CLK(clk), .RSTN(rstn), .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata),
    .DRDATA(a_rdata), .RVALID(a_rvld), .ERR(a_err), .RD_CNT(a_rcnt), .WR_CNT(a_wcnt)
  );

  toy_dmem_responder #(.AW(10), .READ_LAT(2), .CNT_W(16)) u_lat2 (
    .CLK(clk), .RSTN(rstn), .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata),
    .DRDATA(b_rdata), .RVALID(b_rvld), .ERR(b_err), .RD_CNT(b_rcnt), .WR_CNT(b_wcnt)
  );

  toy_dmem_responder #(.AW(10), .READ_LAT(1), .CNT_W(4)) u_cnt4 (
    .CLK(clk), .RSTN(rstn), .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata),
    .DRDATA(c_rdata), .RVALID(c_rvld), .ERR(c_err), .RD_CNT(c_rcnt), .WR_CNT(c_wcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic req, input logic rw, input logic [29:0] a, input logic [31:0] d);
    dreq   = req;
    drw    = rw;
    daddr  = a;
    dwdata = d;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_a_rdata"}, a_rdata, 32'd0);
    chk({tag, "_a_rvld"},  32'(a_rvld), 32'd0);
    chk({tag, "_a_err"},   32'(a_err), 32'd0);
    chk({tag, "_a_rcnt"},  32'(a_rcnt), 32'd0);
    chk({tag, "_a_wcnt"},  32'(a_wcnt), 32'd0);
    chk({tag, "_b_rdata"}, b_rdata, 32'd0);
    chk({tag, "_b_rvld"},  32'(b_rvld), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    set_req(1'b0, 1'b0, 30'd0, 32'd0);

    // Reset held for three cycles with no requests
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_state("rst");
    end
    rstn = 1'b1;
    tick();
    chk_reset_state("rst_rel");

    // Write then read-after-write on address 5
    set_req(1'b1, 1'b1, 30'd5, 32'hDEADBEEF);
    tick();
    chk("raw_w_rvld", 32'(a_rvld), 32'd0);
    set_req(1'b1, 1'b0, 30'd5, 32'd0);
    tick();
    set_req(1'b0, 1'b0, 30'd0, 32'd0);
    chk("raw_a_rvld", 32'(a_rvld), 32'd1);
    chk("raw_a_data", a_rdata, 32'hDEADBEEF);
    chk("raw_a_wcnt", 32'(a_wcnt), 32'd1);
    chk("raw_a_rcnt", 32'(a_rcnt), 32'd1);
    chk("raw_b_early", 32'(b_rvld), 32'd0);
    tick();
    chk("raw_a_drop", 32'(a_rvld), 32'd0);
    chk("raw_a_hold", a_rdata, 32'hDEADBEEF);
    chk("raw_b_rvld", 32'(b_rvld), 32'd1);
    chk("raw_b_data", b_rdata, 32'hDEADBEEF);
    tick();
    chk("raw_b_drop", 32'(b_rvld), 32'd0);
    chk("raw_b_hold", b_rdata, 32'hDEADBEEF);

    // Four writes, then four back-to-back reads in reverse order
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'b1, 30'(i), 32'(10 * (i + 1)));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'b0, 30'(3 - i), 32'd0);
      tick();
      chk($sformatf("b2b_a_rvld%0d", i), 32'(a_rvld), 32'd1);
      chk($sformatf("b2b_a_data%0d", i), a_rdata, 32'(40 - 10 * i));
      if (i == 0) begin
        chk("b2b_b_rvld0", 32'(b_rvld), 32'd0);
      end else begin
        chk($sformatf("b2b_b_rvld%0d", i), 32'(b_rvld), 32'd1);
        chk($sformatf("b2b_b_data%0d", i), b_rdata, 32'(50 - 10 * i));
      end
    end
    set_req(1'b0, 1'b0, 30'd0, 32'd0);
    tick();
    chk("b2b_a_end", 32'(a_rvld), 32'd0);
    chk("b2b_b_rvld4", 32'(b_rvld), 32'd1);
    chk("b2b_b_data4", b_rdata, 32'd10);
    tick();
    chk("b2b_b_end", 32'(b_rvld), 32'd0);
    chk("b2b_a_wcnt", 32'(a_wcnt), 32'd5);
    chk("b2b_a_rcnt", 32'(a_rcnt), 32'd5);
    chk("b2b_a_err", 32'(a_err), 32'd0);

    // Out-of-range read and write
    set_req(1'b1, 1'b0, 30'h0000_0400, 32'd0);
    tick();
    chk("oor_a_rvld", 32'(a_rvld), 32'd1);
    chk("oor_a_data", a_rdata, 32'd0);
    chk("oor_a_err", 32'(a_err), 32'd1);
    set_req(1'b1, 1'b1, 30'h0000_0400, 32'h1234_5678);
    tick();
    chk("oor_b_rvld", 32'(b_rvld), 32'd1);
    chk("oor_b_data", b_rdata, 32'd0);
    chk("oor_b_err", 32'(b_err), 32'd1);
    chk("oor_a_wcnt", 32'(a_wcnt), 32'd6);
    set_req(1'b1, 1'b0, 30'd0, 32'd0);
    tick();
    set_req(1'b0, 1'b0, 30'd0, 32'd0);
    chk("oor_mem0_a", a_rdata, 32'd10);
    chk("oor_a_rcnt", 32'(a_rcnt), 32'd7);
    tick();
    chk("oor_mem0_b", b_rdata, 32'd10);
    chk("oor_err_sticky", 32'(a_err), 32'd1);

    // Reset while a latency-2 read is in flight
    set_req(1'b1, 1'b0, 30'd5, 32'd0);
    tick();
    set_req(1'b0, 1'b0, 30'd0, 32'd0);
    rstn = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    chk("mid_rst_err", 32'(b_err), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_b_rvld%0d", i), 32'(b_rvld), 32'd0);
      chk($sformatf("post_rst_b_data%0d", i), b_rdata, 32'd0);
    end

    // Counter saturation on the 4-bit instance; RAM survives reset
    for (int i = 0; i < 20; i++) begin
      set_req(1'b1, 1'b0, 30'd5, 32'd0);
      tick();
      chk($sformatf("sat_c_rcnt%0d", i), 32'(c_rcnt), (i < 15) ? 32'(i + 1) : 32'd15);
    end
    set_req(1'b0, 1'b0, 30'd0, 32'd0);
    tick();
    chk("sat_c_rcnt_end", 32'(c_rcnt), 32'd15);
    chk("sat_c_wcnt", 32'(c_wcnt), 32'd0);
    chk("sat_a_rcnt", 32'(a_rcnt), 32'd20);
    chk("sat_c_err", 32'(c_err), 32'd0);
    chk("ram_kept_c", c_rdata, 32'hDEADBEEF);
    chk("ram_kept_c_rvld", 32'(c_rvld), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
